// File: rtl/vga_timing_gen.sv
// 640x480@60 Hz VGA raster timing generator with registered, zero-lag sync/DE/coordinate outputs.
// Define VGA_TEST_PATTERN_EN to drive an 8-bar colour pattern on rgb; otherwise rgb is tied to zero.
module vga_timing_gen #(
    parameter int unsigned H_ACTIVE = 640,
    parameter int unsigned H_FP     = 16,
    parameter int unsigned H_SYNC   = 96,
    parameter int unsigned H_BP     = 48,
    parameter int unsigned V_ACTIVE = 480,
    parameter int unsigned V_FP     = 10,
    parameter int unsigned V_SYNC   = 2,
    parameter int unsigned V_BP     = 33,
    parameter bit          SYNC_POL = 1'b0
) (
    input  logic        clk,
    input  logic        resetn,
    output logic        VGAMOD_HS,
    output logic        VGAMOD_VS,
    output logic        de,
    output logic [9:0]  x,
    output logic [9:0]  y,
    output logic        line_start,
    output logic        frame_start,
    output logic [7:0]  frame_cnt,
    output logic [11:0] rgb
);

    localparam int unsigned CW      = 10;
    localparam int unsigned BW      = CW + 1;
    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Boundaries carry one extra bit so a 1024-count total still compares correctly.
    localparam logic [CW-1:0] H_MAX  = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] V_MAX  = CW'(V_TOTAL - 1);
    localparam logic [BW-1:0] H_ACT  = BW'(H_ACTIVE);
    localparam logic [BW-1:0] V_ACT  = BW'(V_ACTIVE);
    localparam logic [BW-1:0] HS_BEG = BW'(H_ACTIVE + H_FP);
    localparam logic [BW-1:0] HS_END = BW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [BW-1:0] VS_BEG = BW'(V_ACTIVE + V_FP);
    localparam logic [BW-1:0] VS_END = BW'(V_ACTIVE + V_FP + V_SYNC);

    logic [CW-1:0] h_q, h_d, v_q, v_d;
    logic          hs_q, hs_d, vs_q, vs_d, de_q, de_d;
    logic [CW-1:0] x_q, x_d, y_q, y_d;
    logic          ls_q, ls_d, fs_q, fs_d;
    logic [7:0]    fc_q, fc_d;

    // Next position and its decode; outputs register the decode of the position being entered.
    always_comb begin
        h_d  = h_q;
        v_d  = v_q;
        hs_d = ~SYNC_POL;
        vs_d = ~SYNC_POL;
        de_d = 1'b0;
        x_d  = '0;
        y_d  = '0;
        ls_d = 1'b0;
        fs_d = 1'b0;
        fc_d = fc_q;

        if (h_q == H_MAX) begin
            h_d = '0;
            v_d = (v_q == V_MAX) ? '0 : v_q + CW'(1);
        end else begin
            h_d = h_q + CW'(1);
        end

        de_d = ({1'b0, h_d} < H_ACT) && ({1'b0, v_d} < V_ACT);
        if (({1'b0, h_d} >= HS_BEG) && ({1'b0, h_d} < HS_END)) hs_d = SYNC_POL;
        if (({1'b0, v_d} >= VS_BEG) && ({1'b0, v_d} < VS_END)) vs_d = SYNC_POL;
        if (de_d) begin
            x_d = h_d;
            y_d = v_d;
        end
        ls_d = (h_d == '0);
        fs_d = (h_d == '0) && (v_d == '0);
        if (fs_d) fc_d = fc_q + 8'd1;
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            h_q  <= H_MAX;
            v_q  <= V_MAX;
            hs_q <= ~SYNC_POL;
            vs_q <= ~SYNC_POL;
            de_q <= 1'b0;
            x_q  <= '0;
            y_q  <= '0;
            ls_q <= 1'b0;
            fs_q <= 1'b0;
            fc_q <= 8'hFF;
        end else begin
            h_q  <= h_d;
            v_q  <= v_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
            de_q <= de_d;
            x_q  <= x_d;
            y_q  <= y_d;
            ls_q <= ls_d;
            fs_q <= fs_d;
            fc_q <= fc_d;
        end
    end

`ifdef VGA_TEST_PATTERN_EN
    localparam int unsigned BAR_W = H_ACTIVE / 8;

    logic [2:0]  bar_c;
    logic [11:0] rgb_q, rgb_d;

    // Bar index bits select full-scale R/G/B; blanking forces black.
    always_comb begin
        rgb_d = '0;
        bar_c = 3'(x_d / CW'(BAR_W));
        if (de_d) rgb_d = {{4{bar_c[2]}}, {4{bar_c[1]}}, {4{bar_c[0]}}};
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) rgb_q <= '0;
        else         rgb_q <= rgb_d;
    end

    assign rgb = rgb_q;
`else
    assign rgb = 12'h000;
`endif

    assign VGAMOD_HS   = hs_q;
    assign VGAMOD_VS   = vs_q;
    assign de          = de_q;
    assign x           = x_q;
    assign y           = y_q;
    assign line_start  = ls_q;
    assign frame_start = fs_q;
    assign frame_cnt   = fc_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Scoreboard bench for vga_timing_gen: a full-width raster with short frames, plus a tiny raster for frame_cnt wrap.
module tb_vga_timing_gen;

    // Instance A: real horizontal timing, 8-line frames (6400 cycles).
    localparam int AHA = 640, AHF = 16, AHS = 96, AHB = 48;
    localparam int AVA = 4,   AVF = 1,  AVS = 2,  AVB = 1;
    // Instance B: 16x5 raster (80-cycle frames) so 256 frames fit in a short run.
    localparam int BHA = 8, BHF = 2, BHS = 2, BHB = 4;
    localparam int BVA = 2, BVF = 1, BVS = 1, BVB = 1;

    typedef struct packed {
        logic        hs;
        logic        vs;
        logic        de;
        logic [9:0]  x;
        logic [9:0]  y;
        logic        ls;
        logic        fs;
        logic [7:0]  fc;
        logic [11:0] rgb;
    } exp_t;

    typedef struct packed {
        exp_t a;
        exp_t b;
    } pair_t;

    logic clk;
    logic resetn;

    logic        a_hs, a_vs, a_de, a_ls, a_fs;
    logic [9:0]  a_x, a_y;
    logic [7:0]  a_fc;
    logic [11:0] a_rgb;
    logic        b_hs, b_vs, b_de, b_ls, b_fs;
    logic [9:0]  b_x, b_y;
    logic [7:0]  b_fc;
    logic [11:0] b_rgb;

    exp_t  act_a, act_b;
    pair_t sb_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;
    int    t        = 0;
    int    n_meas   = 0;

    vga_timing_gen #(
        .H_ACTIVE(AHA), .H_FP(AHF), .H_SYNC(AHS), .H_BP(AHB),
        .V_ACTIVE(AVA), .V_FP(AVF), .V_SYNC(AVS), .V_BP(AVB),
        .SYNC_POL(1'b0)
    ) u_dut_a (
        .clk(clk), .resetn(resetn),
        .VGAMOD_HS(a_hs), .VGAMOD_VS(a_vs), .de(a_de), .x(a_x), .y(a_y),
        .line_start(a_ls), .frame_start(a_fs), .frame_cnt(a_fc), .rgb(a_rgb)
    );

    vga_timing_gen #(
        .H_ACTIVE(BHA), .H_FP(BHF), .H_SYNC(BHS), .H_BP(BHB),
        .V_ACTIVE(BVA), .V_FP(BVF), .V_SYNC(BVS), .V_BP(BVB),
        .SYNC_POL(1'b0)
    ) u_dut_b (
        .clk(clk), .resetn(resetn),
        .VGAMOD_HS(b_hs), .VGAMOD_VS(b_vs), .de(b_de), .x(b_x), .y(b_y),
        .line_start(b_ls), .frame_start(b_fs), .frame_cnt(b_fc), .rgb(b_rgb)
    );

    assign act_a = {a_hs, a_vs, a_de, a_x, a_y, a_ls, a_fs, a_fc, a_rgb};
    assign act_b = {b_hs, b_vs, b_de, b_x, b_y, b_ls, b_fs, b_fc, b_rgb};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected outputs t cycles after reset release (t=0 is the (0,0) cycle); active-low syncs.
    function automatic exp_t model(int tc, int ha, int hf, int hsw, int hb,
                                   int va, int vf, int vsw, int vb);
        int   ht = ha + hf + hsw + hb;
        int   vt = va + vf + vsw + vb;
        int   h, v, k;
        exp_t e;
        h = tc % ht;
        v = (tc / ht) % vt;
        e = '0;
        e.de = (h < ha) && (v < va);
        e.hs = !((h >= ha + hf) && (h < ha + hf + hsw));
        e.vs = !((v >= va + vf) && (v < va + vf + vsw));
        if (e.de) begin
            e.x = 10'(h);
            e.y = 10'(v);
        end
        e.ls = (h == 0);
        e.fs = (h == 0) && (v == 0);
        e.fc = 8'(tc / (ht * vt));
`ifdef VGA_TEST_PATTERN_EN
        if (e.de) begin
            k = h / (ha / 8);
            e.rgb = {(k[2] ? 4'hF : 4'h0), (k[1] ? 4'hF : 4'h0), (k[0] ? 4'hF : 4'h0)};
        end
`else
        k = 0;
`endif
        return e;
    endfunction

    function automatic exp_t reset_exp();
        exp_t e;
        e    = '0;
        e.hs = 1'b1;
        e.vs = 1'b1;
        e.fc = 8'hFF;
        return e;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Stimulus side: push the expected response for every active edge.
    always @(posedge clk) begin : driver
        pair_t p;
        if (!resetn) begin
            p.a = reset_exp();
            p.b = reset_exp();
            t   = 0;
        end else begin
            p.a = model(t, AHA, AHF, AHS, AHB, AVA, AVF, AVS, AVB);
            p.b = model(t, BHA, BHF, BHS, BHB, BVA, BVF, BVS, BVB);
            t++;
        end
        sb_q.push_back(p);
    end

    int hs_run = 0, vs_run = 0, cyc = 0, last_fs = 0;
    bit fs_seen = 1'b0;

    // Monitor: pop and compare every cycle, and measure pulse widths / frame period on instance A.
    always @(negedge clk) begin : monitor
        pair_t p;
        if (sb_q.size() > 0) begin
            p = sb_q.pop_front();
            chk("dut_a_outputs", 64'(act_a), 64'(p.a));
            chk("dut_b_outputs", 64'(act_b), 64'(p.b));
        end
        cyc++;
        if (!resetn) begin
            hs_run  = 0;
            vs_run  = 0;
            fs_seen = 1'b0;
        end else begin
            if (a_hs == 1'b0) hs_run++;
            else if (hs_run != 0) begin
                chk("hs_low_width", 64'(hs_run), 64'(AHS));
                n_meas++;
                hs_run = 0;
            end
            if (a_vs == 1'b0) vs_run++;
            else if (vs_run != 0) begin
                chk("vs_low_width", 64'(vs_run), 64'(AVS * (AHA + AHF + AHS + AHB)));
                n_meas++;
                vs_run = 0;
            end
            if (a_fs) begin
                if (fs_seen) begin
                    chk("frame_period", 64'(cyc - last_fs),
                        64'((AHA + AHF + AHS + AHB) * (AVA + AVF + AVS + AVB)));
                    n_meas++;
                end
                fs_seen = 1'b1;
                last_fs = cyc;
            end
        end
    end

    initial begin
        resetn = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 resetn = 1'b1;
        // Past frame_cnt wrap on B; stop A at h=300, v=2 of its fourth frame.
        repeat (21101) @(posedge clk);
        @(negedge clk);
        #1 resetn = 1'b0;
        #1;
        chk("async_reset_a", 64'(act_a), 64'(reset_exp()));
        chk("async_reset_b", 64'(act_b), 64'(reset_exp()));
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2 resetn = 1'b1;
        repeat (7000) @(posedge clk);
        @(negedge clk);
        #1;
        chk("scoreboard_drained", 64'(sb_q.size()), 64'd0);
        chk("measurement_count", 64'(n_meas), 64'd42);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
